// File: rtl/board_win_scanner.sv
// Scans the 3x3 board RAM after a move: reads the eight lines back-to-back
// and reports the first winning line, or a tie when the board is full.
module board_win_scanner #(
    parameter int CELL_W = 2,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [CELL_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              win,
    output logic              tie,
    output logic [CELL_W-1:0] winner,
    output logic [2:0]        win_line
);

    // Handshake: start is a request sampled only in IDLE; done is a one-cycle
    // pulse after which win/tie/winner/win_line stay stable until the next
    // accepted start. There is no backpressure and requests never queue.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0]        LAST_RD = 5'd24;
    localparam logic [CELL_W-1:0] CELL_X  = CELL_W'(1);
    localparam logic [CELL_W-1:0] CELL_O  = CELL_W'(2);

    state_t            state, state_nx;
    logic [4:0]        rd_cnt;
    logic              rx_en;
    logic [1:0]        rx_pos;
    logic [2:0]        rx_line;
    logic [CELL_W-1:0] cell0, cell1;
    logic              empty_seen;

    logic third_lands;
    logic line_win;
    logic line_empty;
    logic last_line;

    // Read k visits cell (k mod 3) of line (k div 3).
    function automatic logic [3:0] read_cell(input logic [4:0] k);
        logic [3:0] c;
        case (k)
            5'd0:  c = 4'd0;  5'd1:  c = 4'd1;  5'd2:  c = 4'd2;
            5'd3:  c = 4'd3;  5'd4:  c = 4'd4;  5'd5:  c = 4'd5;
            5'd6:  c = 4'd6;  5'd7:  c = 4'd7;  5'd8:  c = 4'd8;
            5'd9:  c = 4'd0;  5'd10: c = 4'd3;  5'd11: c = 4'd6;
            5'd12: c = 4'd1;  5'd13: c = 4'd4;  5'd14: c = 4'd7;
            5'd15: c = 4'd2;  5'd16: c = 4'd5;  5'd17: c = 4'd8;
            5'd18: c = 4'd0;  5'd19: c = 4'd4;  5'd20: c = 4'd8;
            5'd21: c = 4'd2;  5'd22: c = 4'd4;  5'd23: c = 4'd6;
            default: c = 4'd0;
        endcase
        return c;
    endfunction

    // Codes 00 and 11 both count as an empty square.
    function automatic logic is_empty(input logic [CELL_W-1:0] c);
        return (c == '0) || (c == '1);
    endfunction

    always_comb begin
        third_lands = (state == S_SCAN) && rx_en && (rx_pos == 2'd2);
        line_win    = third_lands && (cell0 == cell1) && (cell1 == rd_data) &&
                      ((rd_data == CELL_X) || (rd_data == CELL_O));
        line_empty  = is_empty(cell0) || is_empty(cell1) || is_empty(rd_data);
        last_line   = (rx_line == 3'd7);
    end

    always_comb begin
        state_nx = state;
        rd_addr  = '0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_SCAN;
            end
            S_SCAN: begin
                busy = 1'b1;
                if (rd_cnt != LAST_RD) rd_addr = ADDR_W'(read_cell(rd_cnt));
                if (line_win || (third_lands && last_line)) state_nx = S_DONE;
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rd_cnt     <= '0;
            rx_en      <= 1'b0;
            rx_pos     <= '0;
            rx_line    <= '0;
            cell0      <= '0;
            cell1      <= '0;
            empty_seen <= 1'b0;
            win        <= 1'b0;
            tie        <= 1'b0;
            winner     <= '0;
            win_line   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rd_cnt     <= '0;
                        rx_en      <= 1'b0;
                        rx_pos     <= '0;
                        rx_line    <= '0;
                        empty_seen <= 1'b0;
                        win        <= 1'b0;
                        tie        <= 1'b0;
                        winner     <= '0;
                        win_line   <= '0;
                    end
                end
                S_SCAN: begin
                    if (rd_cnt != LAST_RD) rd_cnt <= rd_cnt + 5'd1;
                    // RAM latency is one cycle, so data starts landing one cycle in.
                    rx_en <= 1'b1;
                    if (rx_en) begin
                        if (rx_pos == 2'd2) begin
                            rx_pos     <= '0;
                            rx_line    <= rx_line + 3'd1;
                            empty_seen <= empty_seen | line_empty;
                            if (line_win) begin
                                win      <= 1'b1;
                                winner   <= rd_data;
                                win_line <= rx_line;
                            end else if (last_line) begin
                                tie <= ~(empty_seen | line_empty);
                            end
                        end else begin
                            rx_pos <= rx_pos + 2'd1;
                            if (rx_pos == 2'd0) cell0 <= rd_data;
                            else                cell1 <= rd_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_win_scanner.sv
// Directed bench for board_win_scanner with a registered board RAM model.
module tb_board_win_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] rd_addr;
    logic [1:0] rd_data;
    logic       busy, done, win, tie;
    logic [1:0] winner;
    logic [2:0] win_line;

    logic [1:0] mem [0:15];
    int tests = 0;
    int fails = 0;
    int exp_addr [24] = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};

    board_win_scanner #(.CELL_W(2), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .done(done), .win(win), .tie(tie),
        .winner(winner), .win_line(win_line)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_board(input logic [1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
        for (int i = 0; i < 16; i++) mem[i] = 2'b00;
        mem[0] = c0; mem[1] = c1; mem[2] = c2;
        mem[3] = c3; mem[4] = c4; mem[5] = c5;
        mem[6] = c6; mem[7] = c7; mem[8] = c8;
    endtask

    // Pulses start, then walks 40 cycles checking addresses, busy and the result.
    task automatic do_scan(input string name, input int exp_done, input logic exp_win,
                           input logic exp_tie, input logic [1:0] exp_winner,
                           input logic [2:0] exp_line, input int pulse_at);
        int done_cyc;
        int done_cnt;
        done_cyc = -1;
        done_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 40; n++) begin
            start = (n == pulse_at);
            if (n < exp_done && n <= 24)
                check({name, " rd_addr"}, 32'(rd_addr), 32'(exp_addr[n-1]));
            check({name, " busy"}, 32'(busy), 32'(n <= exp_done));
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = n;
                    check({name, " win"}, 32'(win), 32'(exp_win));
                    check({name, " tie"}, 32'(tie), 32'(exp_tie));
                    check({name, " winner"}, 32'(winner), 32'(exp_winner));
                    check({name, " win_line"}, 32'(win_line), 32'(exp_line));
                    check({name, " rd_addr at done"}, 32'(rd_addr), 32'd0);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({name, " done cycle"}, 32'(done_cyc), 32'(exp_done));
        check({name, " done count"}, 32'(done_cnt), 32'd1);
        check({name, " win held"}, 32'(win), 32'(exp_win));
        check({name, " tie held"}, 32'(tie), 32'(exp_tie));
    endtask

    initial begin
        set_board(0,0,0, 0,0,0, 0,0,0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset win", 32'(win), 32'd0);
        check("reset tie", 32'(tie), 32'd0);
        check("reset winner", 32'(winner), 32'd0);
        check("reset win_line", 32'(win_line), 32'd0);
        check("reset rd_addr", 32'(rd_addr), 32'd0);

        do_scan("empty", 26, 1'b0, 1'b0, 2'b00, 3'd0, 0);

        set_board(1,1,1, 0,0,0, 0,0,0);
        do_scan("row0 X", 5, 1'b1, 1'b0, 2'b01, 3'd0, 0);

        // X X O / O O X / O X X
        set_board(1,1,2, 2,2,1, 2,1,1);
        do_scan("diag O", 26, 1'b1, 1'b0, 2'b10, 3'd7, 0);

        // X O X / X O O / O X X
        set_board(1,2,1, 1,2,2, 2,1,1);
        do_scan("full tie", 26, 1'b0, 1'b1, 2'b00, 3'd0, 0);

        set_board(1,2,1, 1,3,2, 2,1,1);
        do_scan("illegal cell", 26, 1'b0, 1'b0, 2'b00, 3'd0, 0);

        // Column 1 and row 1 both O: lowest index (row 1) reported; extra start ignored.
        set_board(0,2,0, 2,2,2, 0,2,0);
        do_scan("multi + pulse", 8, 1'b1, 1'b0, 2'b10, 3'd1, 3);

        // Reset during cycle 10 of a scan.
        set_board(1,1,2, 2,2,1, 2,1,1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset done", 32'(done), 32'd0);
        check("mid reset win", 32'(win), 32'd0);
        check("mid reset win_line", 32'(win_line), 32'd0);
        check("mid reset rd_addr", 32'(rd_addr), 32'd0);
        begin
            int late_done;
            late_done = 0;
            for (int n = 0; n < 30; n++) begin
                if (done === 1'b1) late_done++;
                @(negedge clk);
            end
            check("mid reset no done", 32'(late_done), 32'd0);
        end
        do_scan("after reset", 26, 1'b1, 1'b0, 2'b10, 3'd7, 0);

        // reset and start together: reset wins.
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("reset+start busy", 32'(busy), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("reset+start idle", 32'(busy), 32'd0);

        // start held high: scans chain with one IDLE cycle between.
        set_board(1,1,1, 0,0,0, 0,0,0);
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        repeat (4) @(negedge clk);
        check("held done1", 32'(done), 32'd1);
        check("held win1", 32'(win), 32'd1);
        @(negedge clk);
        check("held idle busy", 32'(busy), 32'd0);
        check("held idle win", 32'(win), 32'd1);
        @(negedge clk);
        check("held rescan busy", 32'(busy), 32'd1);
        check("held rescan cleared", 32'(win), 32'd0);
        repeat (4) @(negedge clk);
        check("held done2", 32'(done), 32'd1);
        check("held win2", 32'(win), 32'd1);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("held stop busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/board_win_scanner.md
# board_win_scanner

Sequencer that owns the board RAM read port after each move and scans the 3x3 board for a winning line or a full board. The game FSM pulses `start` after its write-enable state and waits for `done` before branching on `win`/`tie`. The block issues back-to-back reads to the synchronous board RAM and evaluates the eight lines in a fixed order. It stops early on the first win.

## Interface
- CELL_W, 2, width of one board cell (00 empty, 01 player X, 10 player O, 11 illegal, treated as empty)
- ADDR_W, 4, board RAM address width; cells 0..8, row-major
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; one clock; sampled on rising edge of clk
- start  in  1  request a scan; sampled only in IDLE
- rd_addr  out  ADDR_W  board RAM read address
- rd_data  in  CELL_W  board RAM read data, valid one cycle after rd_addr (registered RAM)
- busy  out  1  high while a scan is in progress, including the done cycle
- done  out  1  single-cycle pulse: result valid
- win  out  1  a line of three equal non-empty cells was found
- tie  out  1  no win and no empty cell on the board
- winner  out  CELL_W  cell code of the winning player; 00 when win=0
- win_line  out  3  index of the winning line; 0 when win=0

## Operation
- Line order and index: 0:(0,1,2) 1:(3,4,5) 2:(6,7,8) 3:(0,3,6) 4:(1,4,7) 5:(2,5,8) 6:(0,4,8) 7:(2,4,6).
- Read sequence: k = 0..23, address = cell (k mod 3) of line (k div 3). One address is issued per cycle, with no gaps.
- States:
  - IDLE: busy=0, rd_addr=0. On start=1, clear `empty_seen`, the read counter and the result registers, then go to SCAN.
  - SCAN: issue addresses. Capture returning data into a 3-cell line buffer. When the third cell of a line lands, evaluate the line.
    - If all three cells are equal and equal to 01 or 10, latch win=1, winner and win_line, then go to DONE.
    - Any cell equal to 00 or 11 sets empty_seen.
    - After line 7 with no win, latch tie = ~empty_seen and go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Reads issued after a winning line are discarded. The RAM has no side effects on read.
- win, tie, winner and win_line hold their values from the done pulse until the next accepted start, which clears them.
- win and tie are never both 1.
- start is ignored in SCAN and DONE, and does not queue.
- Counter widths: read counter 5 bits (0..23); line index 3 bits. No wrap occurs inside one scan.

## Timing
- Reset values: busy=0, done=0, win=0, tie=0, winner=00, win_line=0, rd_addr=0; state IDLE.
- Cycle numbering: start is sampled high at edge E0; cycle n is the cycle after edge En-1.
- Addresses: address k is driven in cycle k+1. Its data is visible in cycle k+2.
- Line L is evaluated in cycle 3L+4. done is high in cycle 3L+5.
  - Win on line 0: done in cycle 5.
  - Full scan (no win): done in cycle 26.
- busy is high from cycle 1 through the done cycle inclusive.
- A start held high through done is first accepted at the edge after returning to IDLE.
- Reset mid-scan: the next cycle is IDLE with all outputs at reset values. No done pulse is produced.
- reset and start high in the same cycle: reset wins.
- Simultaneous lines: if several lines win, the lowest line index is reported.

## Test plan
- Empty board, start pulse → 24 sequential rd_addr values matching the line order; done in cycle 26; win=0, tie=0.
- Cells 0,1,2 = 01 → done in cycle 5; win=1, winner=01, win_line=0; rd_addr stops advancing after done.
- Diagonal 2,4,6 = 10, other cells a full non-winning mix → done in cycle 26; win=1, winner=10, win_line=7.
- Full board, no line, pattern X O X / X O O / O X X → done in cycle 26; tie=1, win=0. The same pattern with cell 4 = 11 → tie=0.
- Assert reset in cycle 10 of a scan → busy=0 on the next cycle, no done pulse, outputs cleared; a new start then completes normally.
- start pulsed during SCAN, and start held high continuously → the extra pulse is ignored; with start held, a new scan begins after each done with one IDLE cycle between scans; results clear on each accept.
